// File: rtl/relu_arbiter.sv
// relu_arbiter: round-robin share of one pipelined ReLU unit,
// with credit-guarded, in-order, channel-tagged result FIFO.
module relu_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  output logic                     relu_valid_in,
  output logic [DATA_W-1:0]        relu_data_in,
  input  logic                     relu_valid_out,
  input  logic [DATA_W-1:0]        relu_data_out,
  output logic                     res_valid,
  output logic [DATA_W-1:0]        res_data,
  output logic [CH_W-1:0]          res_ch,
  input  logic                     res_ready,
  output logic                     busy,
  output logic                     err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);

  logic [CH_W-1:0]   r_rr;
  logic [CW-1:0]     r_infl;
  logic [CW-1:0]     r_fcnt;
  logic [AW-1:0]     r_twp;
  logic [AW-1:0]     r_trp;
  logic [AW-1:0]     r_fwp;
  logic [AW-1:0]     r_frp;
  logic [CH_W-1:0]   r_tag  [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fdat [FIFO_DEPTH];
  logic [CH_W-1:0]   r_fch  [FIFO_DEPTH];
  logic              r_vin;
  logic [DATA_W-1:0] r_din;
  logic              r_err;

  logic              w_found;
  logic [CH_W-1:0]   w_cand;
  logic [CH_W-1:0]   w_idx;
  logic [CH_W-1:0]   w_nrr;
  logic [CW:0]       w_sum;
  logic              w_credit;
  logic              w_xfer;
  logic              w_wr;
  logic              w_pop;
  logic [DATA_W-1:0] w_sel;

  // circular search for the first valid requester from r_rr
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(r_rr) + k >= NUM_CH)
        w_idx = CH_W'(int'(r_rr) + k - NUM_CH);
      else
        w_idx = CH_W'(int'(r_rr) + k);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_cand  = w_idx;
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_cand == CH_W'(i))
        w_sel = req_data[i*DATA_W +: DATA_W];
  end

  // credit covers both in-flight operands and queued results
  assign w_sum     = {1'b0, r_infl} + {1'b0, r_fcnt};
  assign w_credit  = w_sum < DEPTH;
  assign w_xfer    = w_found & en & w_credit & ~rst;
  assign req_ready = w_xfer ? (NUM_CH'(1) << w_cand) : '0;
  assign w_nrr     = (w_cand == CH_W'(NUM_CH-1)) ? '0 : w_cand + 1'b1;

  assign w_wr      = relu_valid_out & (r_infl != '0);
  assign res_valid = r_fcnt != '0;
  assign w_pop     = res_valid & res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr   <= '0;
      r_infl <= '0;
      r_fcnt <= '0;
      r_twp  <= '0;
      r_trp  <= '0;
      r_fwp  <= '0;
      r_frp  <= '0;
      r_vin  <= 1'b0;
      r_din  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_vin  <= w_xfer;
      r_infl <= r_infl + CW'(w_xfer) - CW'(w_wr);
      r_fcnt <= r_fcnt + CW'(w_wr) - CW'(w_pop);
      if (w_xfer) begin
        r_din <= w_sel;
        r_rr  <= w_nrr;
        r_twp <= r_twp + 1'b1;
      end
      if (w_wr) begin
        r_trp <= r_trp + 1'b1;
        r_fwp <= r_fwp + 1'b1;
      end
      if (w_pop)
        r_frp <= r_frp + 1'b1;
      if (relu_valid_out && r_infl == '0)
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer)
      r_tag[r_twp] <= w_cand;
    if (w_wr) begin
      r_fdat[r_fwp] <= relu_data_out;
      r_fch[r_fwp]  <= r_tag[r_trp];
    end
  end

  assign res_data      = res_valid ? r_fdat[r_frp] : '0;
  assign res_ch        = res_valid ? r_fch[r_frp] : '0;
  assign busy          = (r_infl != '0) | res_valid;
  assign err           = r_err;
  assign relu_valid_in = r_vin;
  assign relu_data_in  = r_din;

endmodule

// File: tb/tb_relu_arbiter.sv
// tb_relu_arbiter: directed + random stimulus against a
// queue-based reference of the arbiter and a 1-cycle ReLU unit.
module tb_relu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        relu_valid_in;
  logic [15:0] relu_data_in;
  logic        relu_valid_out;
  logic [15:0] relu_data_out;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_ch;
  logic        res_ready;
  logic        busy;
  logic        err;
  logic        inj;

  always #5 clk = ~clk;

  relu_arbiter #(
    .NUM_CH(4), .CH_W(2), .DATA_W(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .relu_valid_in(relu_valid_in),
    .relu_data_in(relu_data_in),
    .relu_valid_out(relu_valid_out),
    .relu_data_out(relu_data_out),
    .res_valid(res_valid), .res_data(res_data),
    .res_ch(res_ch), .res_ready(res_ready),
    .busy(busy), .err(err)
  );

  function automatic logic [15:0] relu(input logic [15:0] x);
    return ($signed(x) < 0) ? 16'h0000 : x;
  endfunction

  // external ReLU unit, latency 1
  logic        r_rv;
  logic [15:0] r_rd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rv <= 1'b0;
      r_rd <= '0;
    end else begin
      r_rv <= relu_valid_in;
      r_rd <= relu(relu_data_in);
    end
  end
  assign relu_valid_out = r_rv | inj;
  assign relu_data_out  = r_rd;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] d;
    logic [31:0] t;
  } ent_t;

  ent_t        m_acc[$];
  ent_t        m_fifo[$];
  int          m_rr;
  int          m_edge;
  logic        m_vin;
  logic [15:0] m_din;
  logic        m_err;

  logic [15:0] ops [4][512];
  int          hd[4];
  int          tl[4];

  logic [1:0]  d_pch[$];
  logic [15:0] d_pdat[$];
  int          n_dx;
  int          n_chk;
  int          n_err;

  logic [15:0] vals [5] = '{16'h0101, 16'h8123, 16'h0202,
                            16'h7FFF, 16'h0001};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [15:0] v);
    if (tl[c] < 512) begin
      ops[c][tl[c]] = v;
      tl[c]++;
    end
  endtask

  task automatic mreset();
    m_acc.delete();
    m_fifo.delete();
    m_rr  = 0;
    m_vin = 1'b0;
    m_din = '0;
    m_err = 1'b0;
  endtask

  task automatic drive_req();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (hd[i] != tl[i]);
      req_data[16*i +: 16] = req_valid[i] ? ops[i][hd[i]] : 16'h0;
    end
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < 4; i++) p += tl[i] - hd[i];
    return p;
  endfunction

  // one clock: check at negedge, advance model at posedge
  task automatic step();
    logic [3:0]  exp_rdy;
    logic [15:0] sel;
    int          cand;
    int          out_n;
    bit          found;
    bit          xfer;
    bit          pop;
    drive_req();
    #4;
    found = 0;
    cand  = 0;
    for (int k = 0; k < 4; k++) begin
      int j = (m_rr + k) % 4;
      if (!found && req_valid[j]) begin
        found = 1;
        cand  = j;
      end
    end
    out_n   = m_acc.size() + m_fifo.size();
    exp_rdy = (found && en && out_n < 4) ? 4'(1 << cand) : 4'h0;
    xfer    = (exp_rdy != 4'h0);
    pop     = (m_fifo.size() != 0) && res_ready;
    sel     = ops[cand][hd[cand]];
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(m_fifo.size() != 0));
    chk("res_data", 32'(res_data),
        (m_fifo.size() != 0) ? 32'(m_fifo[0].d) : 32'h0);
    chk("res_ch", 32'(res_ch),
        (m_fifo.size() != 0) ? 32'(m_fifo[0].ch) : 32'h0);
    chk("busy", 32'(busy), 32'(out_n != 0));
    chk("err", 32'(err), 32'(m_err));
    if (|(req_valid & req_ready)) n_dx++;
    if (res_valid && res_ready) begin
      d_pch.push_back(res_ch);
      d_pdat.push_back(res_data);
    end
    @(posedge clk);
    m_edge++;
    if (inj && m_acc.size() == 0) m_err = 1'b1;
    if (pop) void'(m_fifo.pop_front());
    while (m_acc.size() != 0 && m_acc[0].t <= 32'(m_edge))
      m_fifo.push_back(m_acc.pop_front());
    if (xfer) begin
      m_acc.push_back('{ch: 2'(cand), d: relu(sel),
                        t: 32'(m_edge + 2)});
      m_rr = (cand + 1) % 4;
      hd[cand]++;
      m_din = sel;
    end
    m_vin = xfer;
    #1;
    chk("relu_valid_in", 32'(relu_valid_in), 32'(m_vin));
    chk("relu_data_in", 32'(relu_data_in), 32'(m_din));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive_req();
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_relu_valid_in", 32'(relu_valid_in), 32'h0);
    chk("rst_relu_data_in", 32'(relu_data_in), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_data", 32'(res_data), 32'h0);
    chk("rst_res_ch", 32'(res_ch), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(posedge clk);
    #1;
    mreset();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    n_dx  = 0;
    m_edge = 0;
    rst = 1'b0;
    en = 1'b1;
    res_ready = 1'b0;
    inj = 1'b0;
    req_valid = '0;
    req_data = '0;
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    mreset();

    // reset with a request already pending, then single channel
    push(2, 16'h0180);
    push(2, 16'hFF00);
    #1;
    reset_dut();
    res_ready = 1'b1;
    d_pch.delete();
    d_pdat.delete();
    repeat (6) step();
    chk("t2_count", 32'(d_pch.size()), 32'd2);
    chk("t2_d0", 32'(d_pdat[0]), 32'h0180);
    chk("t2_c0", 32'(d_pch[0]), 32'd2);
    chk("t2_d1", 32'(d_pdat[1]), 32'h0000);
    chk("t2_c1", 32'(d_pch[1]), 32'd2);

    // round-robin fairness at full rate
    reset_dut();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) push(c, 16'($urandom));
    d_pch.delete();
    repeat (15) step();
    chk("t3_count", 32'(d_pch.size()), 32'd12);
    for (int k = 0; k < 12; k++)
      chk("t3_ch", 32'(d_pch[k]), 32'(k % 4));

    // credit backpressure
    res_ready = 1'b0;
    n_dx = 0;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) push(c, 16'($urandom));
    repeat (8) step();
    chk("t4_xfers", 32'(n_dx), 32'd4);
    chk("t4_block", 32'(req_ready), 32'h0);
    chk("t4_full", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    d_pch.delete();
    repeat (20) step();
    for (int k = 0; k < 8; k++)
      chk("t4_order", 32'(d_pch[k]), 32'(k % 4));
    chk("t4_idle", 32'(busy), 32'h0);

    // pop and write together with three results queued
    for (int k = 0; k < 5; k++) push(1, vals[k]);
    res_ready = 1'b0;
    d_pdat.delete();
    repeat (5) step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t5_one_pop", 32'(d_pdat.size()), 32'd1);
    chk("t5_still_full", 32'(res_valid), 32'd1);
    repeat (2) step();
    res_ready = 1'b1;
    repeat (10) step();
    for (int k = 0; k < 5; k++)
      chk("t5_data", 32'(d_pdat[k]), 32'(relu(vals[k])));

    // enable gating, then spurious ReLU result
    for (int k = 0; k < 3; k++) push(0, 16'($urandom));
    push(3, 16'h1234);
    step();
    en = 1'b0;
    n_dx = 0;
    repeat (6) step();
    chk("t6_no_xfer", 32'(n_dx), 32'h0);
    chk("t6_drained", 32'(busy), 32'h0);
    inj = 1'b1;
    step();
    inj = 1'b0;
    repeat (3) step();
    chk("t6_err_sticky", 32'(err), 32'd1);
    en = 1'b1;
    repeat (10) step();
    chk("t6_err_hold", 32'(err), 32'd1);
    reset_dut();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(7) == 0) push(c, 16'($urandom));
      res_ready = ($urandom_range(3) != 0);
      en = ($urandom_range(7) != 0);
      step();
    end

    // asynchronous reset with work outstanding
    res_ready = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 4; c++) push(c, 16'($urandom));
    for (int n = 0; n < 10 && (m_acc.size() + m_fifo.size()) < 3; n++)
      step();
    chk("t1_busy_before", 32'(busy), 32'd1);
    reset_dut();
    en = 1'b0;
    repeat (3) step();
    chk("t1_res_valid", 32'(res_valid), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_err", 32'(err), 32'h0);

    // final drain
    en = 1'b1;
    res_ready = 1'b1;
    for (int n = 0; n < 2000 &&
         (pending() != 0 || (m_acc.size() + m_fifo.size()) != 0); n++)
      step();
    repeat (2) step();
    chk("final_idle", 32'(busy), 32'h0);
    chk("final_ready", 32'(req_ready), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/relu_arbiter.md
# relu_arbiter

Round-robin scheduler that shares one pipelined ReLU unit among NUM_CH Q8.8 requesters. It accepts one operand per cycle from the winning requester, drives the ReLU unit's valid/data inputs, and tracks channel tags for operands in flight. It collects ReLU results in an in-order result FIFO and returns them, tagged with their source channel, on a single backpressured result port. Credit accounting guarantees the result FIFO never overflows, because the ReLU unit itself cannot stall.

## Interface
Parameters:
- NUM_CH, 4: number of requesters (2..8)
- CH_W, 2: channel tag width, equal to clog2(NUM_CH)
- DATA_W, 16: operand/result width, signed Q8.8
- FIFO_DEPTH, 4: result FIFO entries, which is also the maximum outstanding operands (power of 2, ≥ 2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  grant enable; 0 blocks new grants, while in-flight operands still drain
- req_valid  in  NUM_CH  per-channel operand valid
- req_data  in  NUM_CH*DATA_W  channel i at bits [DATA_W*i+DATA_W-1 : DATA_W*i]
- req_ready  out  NUM_CH  combinational one-hot grant (at most one bit set)
- relu_valid_in  out  1  registered valid to ReLU unit
- relu_data_in  out  DATA_W  registered operand to ReLU unit
- relu_valid_out  in  1  ReLU result valid
- relu_data_out  in  DATA_W  ReLU result
- res_valid  out  1  result FIFO non-empty
- res_data  out  DATA_W  head result
- res_ch  out  CH_W  head result's source channel
- res_ready  in  1  consumer accepts head when res_valid=1
- busy  out  1  in-flight count ≠ 0 or FIFO non-empty
- err  out  1  sticky: relu_valid_out arrived with in-flight count = 0

## Operation
**Counters**
- inflight counts operands accepted whose result is not yet written to the FIFO.
- fcount counts the FIFO occupancy.
- credit_ok = (inflight + fcount < FIFO_DEPTH).

**Grant**
- Candidate is the first i with req_valid[i]=1, searching circularly from rr_ptr.
- req_ready[candidate] = en & credit_ok. All other req_ready bits are 0.
- Transfer occurs when req_valid[i] & req_ready[i].

**On transfer**
- relu_data_in ← selected operand; relu_valid_in ← 1.
- Channel tag is pushed into the tag queue (depth FIFO_DEPTH).
- rr_ptr ← (granted + 1) mod NUM_CH.
- inflight increments.

**Without transfer**
- relu_valid_in ← 0.
- relu_data_in holds its value.
- rr_ptr holds its value.

**On relu_valid_out = 1**
- Tag queue is popped.
- {tag, relu_data_out} is written to the result FIFO.
- inflight decrements and fcount increments.
- If inflight = 0 at this point: no write, set err.

**Result pop**
- Pop occurs when res_valid & res_ready; fcount decrements.
- res_data and res_ch show the head entry (first-word-fall-through).

**Simultaneous events**
- Transfer, ReLU write and result pop in the same cycle all take effect; each counter applies its net change.
- Popping the last FIFO entry while a result is written leaves one entry (the new result).

**Width and order**
- Data passes through unmodified; no arithmetic is performed.
- Ordering is strict: results leave in acceptance order across all channels.

**Reset**
- Reset is asynchronous at any time, including mid-operation.
- Clears: rr_ptr=0, inflight=0, fcount=0, tag and FIFO pointers=0, relu_valid_in=0, relu_data_in=0, err=0.
- Results of in-flight operands are discarded. A relu_valid_out arriving after reset sets err.

## Timing
**Reset values of outputs**
- req_ready=0 (because req_valid is ignored while rst=1).
- relu_valid_in=0, relu_data_in=0.
- res_valid=0, res_data=0, res_ch=0.
- busy=0, err=0.

**Latency**
- Transfer at edge E0 → relu_valid_in high for the cycle after E0.
- With ReLU latency L=1: relu_valid_out high after E1 → FIFO write at E2.
- res_valid is high after E2 if the FIFO was empty. Minimum accept-to-result latency is 2 + (L−1) cycles.

**Throughput**
- One operand per cycle while credit_ok holds.
- With res_ready tied 1 and FIFO_DEPTH ≥ L+2, throughput is sustained at 1/cycle.

**Backpressure**
- req_ready drops in the same cycle credit_ok goes false.
- The requester must hold req_valid and req_data until it sees a transfer.

**en**
- en=0 forces req_ready=0 in that cycle. Outstanding results still drain.

## Test plan
1. **Reset checks.** Reset held → all outputs at reset values. Assert rst mid-stream with 3 operands in flight → after release, res_valid=0, busy=0, err=0.
2. **Single channel.** Ch2 sends 0x0180 then 0xFF00, res_ready=1, ReLU L=1.
   - Required: res_data=0x0180 with res_ch=2, 2 cycles after accept.
   - Then res_data=0x0000 with res_ch=2 on the next cycle.
3. **Round-robin fairness.** All 4 channels hold req_valid continuously.
   - Grants rotate 0,1,2,3,0…
   - res_ch follows the same sequence at 1 result/cycle.
4. **Credit backpressure.** res_ready=0, FIFO_DEPTH=4, 4 channels valid.
   - Exactly 4 transfers occur, then req_ready=0. fcount reaches 4 with no overflow.
   - Raise res_ready → 4 results drain in acceptance order, then grants resume.
5. **Simultaneous push/pop at full.** With fcount=3, inflight=1, pop and write in the same cycle → fcount stays 3 and data order is preserved.
6. **Enable and error.**
   - en=0 with requests pending → no transfer, busy falls after drain.
   - Inject relu_valid_out with inflight=0 → err=1 and stays 1 until rst.
